// File: rtl/axis_replay_egress.sv
// FIFO-to-AXI4-Stream egress for the replay engine: buffers header+data words,
// emits them cut-through or store-and-forward with a programmable inter-packet gap.
module axis_replay_egress #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH           = 64,
  parameter int ALMOST_FULL_THRESH   = 4
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic                              sw_rst,
  input  logic                              fifo_wr_en,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]    fifo_din,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  fifo_din_strb,
  input  logic                              fifo_din_last,
  output logic                              fifo_full,
  output logic                              fifo_almost_full,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              cfg_store_fwd,
  input  logic [15:0]                       cfg_ipg,
  output logic [31:0]                       stat_pkt_count,
  output logic [31:0]                       stat_byte_count,
  output logic [31:0]                       stat_drop_count
);
  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int TW = C_M_AXIS_TUSER_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RD_HDR, RD_PKT, GAP} rd_state_t;

  function automatic logic [31:0] popcount(input logic [SW-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < SW; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  logic          rst;
  logic [DW-1:0] mem_data_q [FIFO_DEPTH];
  logic [SW-1:0] mem_strb_q [FIFO_DEPTH];
  logic          mem_last_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] complete_q, complete_d;
  logic          full_q, afull_q, full_d, afull_d;
  logic          wr_expect_hdr_q;
  rd_state_t     state_q, state_d;
  logic [15:0]   gap_q, gap_d;
  logic [TW-1:0] tuser_q, tuser_d;
  logic [31:0]   pkt_q, byte_q, drop_q;

  logic          empty, wr_acc, wr_drop, wr_pkt_end;
  logic          pop, beat, pkt_done, tvalid, eligible;
  logic [DW-1:0] head_data;
  logic [SW-1:0] head_strb;
  logic          head_last;

  assign rst        = !axi_aresetn || sw_rst;
  assign empty      = (count_q == '0);
  assign wr_acc     = fifo_wr_en && !full_q;
  assign wr_drop    = fifo_wr_en && full_q;
  assign wr_pkt_end = wr_acc && !wr_expect_hdr_q && fifo_din_last;
  assign head_data  = mem_data_q[rptr_q];
  assign head_strb  = mem_strb_q[rptr_q];
  assign head_last  = mem_last_q[rptr_q];

  always_ff @(posedge axi_aclk) begin
    if (wr_acc) begin
      mem_data_q[wptr_q] <= fifo_din;
      mem_strb_q[wptr_q] <= fifo_din_strb;
      mem_last_q[wptr_q] <= fifo_din_last;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    tuser_d  = tuser_q;
    pop      = 1'b0;
    beat     = 1'b0;
    pkt_done = 1'b0;
    tvalid   = 1'b0;
    eligible = !empty && (!cfg_store_fwd || (complete_q != '0));
    case (state_q)
      RD_HDR: begin
        if (eligible) begin
          pop     = 1'b1;
          tuser_d = head_data[TW-1:0];
          state_d = RD_PKT;
        end
      end
      RD_PKT: begin
        tvalid = !empty;
        if (tvalid && m_axis_tready) begin
          pop  = 1'b1;
          beat = 1'b1;
          if (head_last) begin
            pkt_done = 1'b1;
            if (cfg_ipg != 16'd0) begin
              gap_d   = cfg_ipg;
              state_d = GAP;
            end else begin
              state_d = RD_HDR;
            end
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 16'd1;
        if (gap_q <= 16'd1) state_d = RD_HDR;
      end
      default: state_d = RD_HDR;
    endcase
  end

  // Flags are registered against the post-edge occupancy, so a write
  // racing a read on a full FIFO still sees full and is dropped.
  always_comb begin
    count_d    = count_q + CW'(wr_acc) - CW'(pop);
    complete_d = complete_q + CW'(wr_pkt_end) - CW'(pkt_done);
    full_d     = (count_d == CW'(FIFO_DEPTH));
    afull_d    = ((CW'(FIFO_DEPTH) - count_d) <= CW'(ALMOST_FULL_THRESH));
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      complete_q      <= '0;
      full_q          <= 1'b0;
      afull_q         <= 1'b0;
      wr_expect_hdr_q <= 1'b1;
      state_q         <= RD_HDR;
      gap_q           <= '0;
      tuser_q         <= '0;
      pkt_q           <= '0;
      byte_q          <= '0;
      drop_q          <= '0;
    end else begin
      if (wr_acc) begin
        wptr_q <= wptr_q + AW'(1);
        if (wr_expect_hdr_q)   wr_expect_hdr_q <= 1'b0;
        else if (fifo_din_last) wr_expect_hdr_q <= 1'b1;
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q    <= count_d;
      complete_q <= complete_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      tuser_q    <= tuser_d;
      if (wr_drop)  drop_q <= drop_q + 32'd1;
      if (beat)     byte_q <= byte_q + popcount(head_strb);
      if (pkt_done) pkt_q  <= pkt_q + 32'd1;
    end
  end

  assign fifo_full        = full_q;
  assign fifo_almost_full = afull_q;
  assign m_axis_tvalid    = tvalid;
  assign m_axis_tdata     = head_data;
  assign m_axis_tstrb     = head_strb;
  assign m_axis_tlast     = tvalid && head_last;
  assign m_axis_tuser     = tuser_q;
  assign stat_pkt_count   = pkt_q;
  assign stat_byte_count  = byte_q;
  assign stat_drop_count  = drop_q;

endmodule

// File: doc/axis_replay_egress.md
# axis_replay_egress

Single-clock successor to the replay engine's FIFO-to-AXI-Stream stage. It buffers a packed word stream (header word carrying TUSER, then data words with byte strobes and an explicit last flag) in an internal synchronous FIFO of parametrised depth. It emits the stream as AXI4-Stream, in cut-through or store-and-forward mode. It also supports a programmable inter-packet gap and keeps packet, byte and drop statistics. It sits between the pcap replay micro-engine and the output port arbiter.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256: TDATA width; multiple of 8, must be ≥ C_M_AXIS_TUSER_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128: TUSER width.
- FIFO_DEPTH, 64: entries; power of two, ≥ 4; must hold the largest packet plus header in store-and-forward mode.
- ALMOST_FULL_THRESH, 4: fifo_almost_full asserts when free entries ≤ this.

Ports:
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  synchronous, active-low reset.
- sw_rst  in  1  synchronous, active-high soft reset; same effect as reset.
- fifo_wr_en  in  1  write strobe.
- fifo_din  in  C_M_AXIS_DATA_WIDTH  word data; for a header word, TUSER is fifo_din[C_M_AXIS_TUSER_WIDTH-1:0].
- fifo_din_strb  in  C_M_AXIS_DATA_WIDTH/8  byte strobes; ignored on header words.
- fifo_din_last  in  1  last data word of the packet; ignored on header words.
- fifo_full  out  1  no free entry.
- fifo_almost_full  out  1  see ALMOST_FULL_THRESH.
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH.
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH.
- m_axis_tvalid  out  1.
- m_axis_tready  in  1.
- m_axis_tlast  out  1.
- cfg_store_fwd  in  1  1 = store-and-forward, 0 = cut-through.
- cfg_ipg  in  16  idle cycles inserted after each tlast.
- stat_pkt_count  out  32  packets sent; count wraps.
- stat_byte_count  out  32  sum of set tstrb bits over accepted beats; count wraps.
- stat_drop_count  out  32  writes discarded while full; count wraps.

## Operation
- Write side: a flag wr_expect_hdr resets to 1.
  - Each accepted write with wr_expect_hdr=1 is a header; it clears the flag.
  - An accepted non-header write with fifo_din_last=1 sets the flag and increments complete_pkts.
- A write with fifo_wr_en=1 while fifo_full=1 is discarded and increments stat_drop_count. A discarded write does not change wr_expect_hdr.
- FIFO is first-word-fall-through: the head entry, its strb and its last bit are visible combinationally while not empty.
- Read FSM states:
  - RD_HDR, reset state: wait for eligibility. In cut-through, eligibility is !empty. In store-and-forward, it is complete_pkts>0. cfg_store_fwd is sampled only in this state. When eligible: pop the header, latch TUSER, go to RD_PKT.
  - RD_PKT: tvalid = !empty. tdata/tstrb/tlast come from the head entry; tuser is the latched value. On tvalid&&tready: pop, add popcount(tstrb) to byte count. If the beat also has tlast: increment stat_pkt_count, decrement complete_pkts, then go to GAP if cfg_ipg≠0 (load the gap counter with cfg_ipg), else go to RD_HDR.
  - GAP: tvalid=0; counter decrements each cycle; go to RD_HDR on the cycle the counter reaches 1.
- complete_pkts increment and decrement in the same cycle: value holds. Width is log2(FIFO_DEPTH)+1.
- Read and write in the same cycle when full: the read frees an entry, but the write is still dropped, because fifo_full is registered from the prior cycle. Read and write when empty: the write lands and no read occurs.
- tvalid, once asserted, holds with stable tdata/tstrb/tlast/tuser until tready.

## Timing
- Reset (axi_aresetn=0 or sw_rst=1 at a clock edge):
  - FIFO emptied; state RD_HDR; all counters 0; wr_expect_hdr=1; latched tuser 0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, fifo_full=0, fifo_almost_full=0.
  - tdata/tstrb are don't-care while tvalid=0.
- Reset mid-packet discards all buffered data. The next written word is treated as a header.
- Write-to-visible latency: an entry written at edge N is visible at the head after edge N.
- Cut-through: header written at cycle 0, popped in cycle 1; the first data word written in cycle 1 gives tvalid in cycle 2 at the earliest.
- One header pop costs one bubble cycle per packet. Beat throughput is one per cycle otherwise.
- IPG: with cfg_ipg=K, exactly K cycles of tvalid=0 in GAP, then one RD_HDR cycle, before the next first beat.
- fifo_full and fifo_almost_full are registered and update one cycle after the occupancy change.

## Test plan
- Cut-through, cfg_ipg=0, tready=1: write header 0xAB then 3 words; the third word has strb=0x0000_FFFF and last=1. Expect 3 beats, tuser=0xAB, tlast on the third beat only, stat_pkt_count=1, stat_byte_count=2×32+16=80.
- Store-and-forward: write header plus 2 words with last withheld for 10 cycles. Expect tvalid=0 throughout. After the last word is written, the packet streams within 3 cycles.
- Backpressure: toggle tready pseudo-randomly over 5 packets. Expect data/tstrb/tlast/tuser stable while tvalid&&!tready, no beat lost or duplicated, and complete_pkts returns to 0.
- Overflow with FIFO_DEPTH=16: write 20 words with tready=0. Expect fifo_full after 16 words, stat_drop_count=4, and fifo_almost_full asserted from 12 occupied entries.
- IPG: cfg_ipg=5, two back-to-back packets. Expect exactly 5 idle cycles plus 1 header cycle between the first tlast handshake and the second packet's first tvalid.
- Reset mid-packet: assert sw_rst after 2 of 4 beats. Expect tvalid=0 and counters 0 the next cycle. A new header plus 1 word then emits correctly with the new tuser.
